// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory/IO bus arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Address bit that selects IO space instead of RAM
    localparam int IO_BIT = 7;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LAT    = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: the master that did not finish last wins a tie.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_gnt
);

    logic w_both;

    assign w_both  = i_req0 & i_req1;
    assign o_valid = i_req0 | i_req1;
    // On a tie alternate away from the previous winner; otherwise take whoever asks
    assign o_gnt   = w_both ? ~i_last : i_req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory/IO bus.
//
// state  | meaning
// IDLE   | bus parked at 0, arbitrate pending requests
// ACCESS | latched command on the bus for LAT cycles, read data sampled in the last one
// DONE   | bus parked at 0, one-cycle ack to the granted master, update fairness pointer
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              mem_io,
    output logic              busy,
    output logic              gnt
);

    localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_last;
    logic              r_gnt;
    logic              r_we;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_datain;
    logic              r_mem_we;
    logic              r_mem_io;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic              w_valid;
    logic              w_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    rr_arb2 u_rr_arb2 (
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_gnt   (w_gnt)
    );

    assign w_sel_we    = w_gnt ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;

    // Sequencer: the bus registers double as the command latches, so the bus is
    // glitch-free and holds the command unchanged through ACCESS.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_last       <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_datain <= '0;
            r_mem_we     <= 1'b0;
            r_mem_io     <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt        <= w_gnt;
                        r_we         <= w_sel_we;
                        r_cnt        <= 3'd0;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_datain <= w_sel_wdata;
                        r_mem_we     <= w_sel_we;
                        r_mem_io     <= w_sel_addr[IO_BIT];
                        r_busy       <= 1'b1;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Write strobe only in the first access cycle
                    r_mem_we <= 1'b0;
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == CNT_LAST) begin
                        if (!r_we) begin
                            if (r_gnt) begin
                                r_m1_rdata <= mem_dataout;
                            end else begin
                                r_m0_rdata <= mem_dataout;
                            end
                        end
                        r_m0_ack     <= ~r_gnt;
                        r_m1_ack     <= r_gnt;
                        r_mem_addr   <= '0;
                        r_mem_datain <= '0;
                        r_mem_io     <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_gnt;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_datain = r_mem_datain;
    assign mem_we     = r_mem_we;
    assign mem_io     = r_mem_io;
    assign busy       = r_busy;
    assign gnt        = r_gnt;
    assign m0_ack     = r_m0_ack;
    assign m1_ack     = r_m1_ack;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;

endmodule
